// File: rtl/coprosit_pkg.sv
// Shared Coprosit coprocessor types: eXtension-interface result payload,
// PRAU result tag, memory completion metadata and result-source encoding.
package coprosit_pkg;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned PRF_AW     = 5;

  typedef enum logic {SrcPrau, SrcMem} res_src_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [PRF_AW-1:0]     addr;
    logic                  rd_is_pos;
  } prau_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  dbg;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic [5:0]            ecsdata;
    logic [2:0]            ecswe;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  err;
    logic                  dbg;
  } x_result_t;

endpackage

// File: rtl/coprosit_rr_arb2.sv
// Two-requester arbiter: req[0] = PRAU, req[1] = memory. Round-robin on ties
// when RR_EN is set, otherwise memory has fixed priority.
module coprosit_rr_arb2
  import coprosit_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  res_src_e last_src, last_src_d;

  always_comb begin
    grant      = '0;
    last_src_d = last_src;
    if (enable && !rst) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (RR_EN && last_src == SrcMem) ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
    if (grant[0]) last_src_d = SrcPrau;
    if (grant[1]) last_src_d = SrcMem;
  end

  always_ff @(posedge clk) begin
    if (rst) last_src <= SrcPrau;
    else     last_src <= last_src_d;
  end

endmodule

// File: rtl/coprosit_result_arbiter.sv
// Shares the X-interface result channel between PRAU and memory completions,
// registering the result payload and the posit register file write port.
module coprosit_result_arbiter
  import coprosit_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          prau_valid_i,
  output logic          prau_ready_o,
  input  logic [31:0]   prau_data_i,
  input  prau_tag_t     prau_tag_i,
  input  logic          mem_valid_i,
  output logic          mem_ready_o,
  input  logic [31:0]   mem_rdata_i,
  input  mem_metadata_t mem_meta_i,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output logic          prf_we_o,
  output logic [4:0]    prf_waddr_o,
  output logic [31:0]   prf_wdata_o,
  output logic          busy_o
);

  logic        can_accept;
  logic [1:0]  grant;
  x_result_t   res_d;
  logic        prf_we_d;
  logic [4:0]  prf_waddr_d;
  logic [31:0] prf_wdata_d;

  assign can_accept = !x_result_valid_o || x_result_ready_i;

  coprosit_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({mem_valid_i, prau_valid_i}),
    .enable (can_accept),
    .grant  (grant)
  );

  assign prau_ready_o = grant[0];
  assign mem_ready_o  = grant[1];
  assign busy_o       = x_result_valid_o;

  always_comb begin
    res_d       = '0;
    prf_we_d    = 1'b0;
    prf_waddr_d = prf_waddr_o;
    prf_wdata_d = prf_wdata_o;
    if (grant[0]) begin
      res_d.id = prau_tag_i.id;
      res_d.rd = prau_tag_i.addr;
      // Posit destinations go to the PRF; the core sees a no-writeback result.
      if (prau_tag_i.rd_is_pos) begin
        prf_we_d    = 1'b1;
        prf_waddr_d = prau_tag_i.addr;
        prf_wdata_d = prau_data_i;
      end else begin
        res_d.we   = 1'b1;
        res_d.data = prau_data_i;
      end
    end else if (grant[1]) begin
      res_d.id      = mem_meta_i.id;
      res_d.rd      = mem_meta_i.rd;
      res_d.exc     = mem_meta_i.exc;
      res_d.exccode = mem_meta_i.exccode;
      res_d.dbg     = mem_meta_i.dbg;
      if (mem_meta_i.we && !mem_meta_i.exc) begin
        prf_we_d    = 1'b1;
        prf_waddr_d = mem_meta_i.rd;
        prf_wdata_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_result_valid_o <= 1'b0;
      x_result_o       <= '0;
      prf_we_o         <= 1'b0;
      prf_waddr_o      <= '0;
      prf_wdata_o      <= '0;
    end else begin
      prf_we_o    <= prf_we_d;
      prf_waddr_o <= prf_waddr_d;
      prf_wdata_o <= prf_wdata_d;
      if (|grant) begin
        x_result_valid_o <= 1'b1;
        x_result_o       <= res_d;
      end else if (x_result_ready_i) begin
        x_result_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coprosit_result_arbiter.sv
// Self-checking bench for coprosit_result_arbiter: one instance with round-robin,
// one with fixed memory priority, both driven by the same stimulus.
module tb_coprosit_result_arbiter;
  import coprosit_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          prau_valid, mem_valid, x_ready;
  logic [31:0]   prau_data, mem_rdata;
  prau_tag_t     prau_tag;
  mem_metadata_t mem_meta;

  logic          prau_ready[2], mem_ready[2], res_valid[2], prf_we[2], busy[2];
  x_result_t     res[2];
  logic [4:0]    waddr[2];
  logic [31:0]   wdata[2];

  // Reference model state, index 0 = round-robin, 1 = fixed priority
  logic          m_valid[2];
  x_result_t     m_res[2];
  logic          m_prf_we[2];
  logic [4:0]    m_waddr[2];
  logic [31:0]   m_wdata[2];
  int            m_last[2];    // 0 = PRAU granted last, 1 = memory
  int            exp_grant[2]; // -1 none, 0 PRAU, 1 memory

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coprosit_result_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .prau_valid_i(prau_valid), .prau_ready_o(prau_ready[0]),
    .prau_data_i(prau_data), .prau_tag_i(prau_tag),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready[0]),
    .mem_rdata_i(mem_rdata), .mem_meta_i(mem_meta),
    .x_result_valid_o(res_valid[0]), .x_result_ready_i(x_ready),
    .x_result_o(res[0]), .prf_we_o(prf_we[0]),
    .prf_waddr_o(waddr[0]), .prf_wdata_o(wdata[0]), .busy_o(busy[0])
  );

  coprosit_result_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .prau_valid_i(prau_valid), .prau_ready_o(prau_ready[1]),
    .prau_data_i(prau_data), .prau_tag_i(prau_tag),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready[1]),
    .mem_rdata_i(mem_rdata), .mem_meta_i(mem_meta),
    .x_result_valid_o(res_valid[1]), .x_result_ready_i(x_ready),
    .x_result_o(res[1]), .prf_we_o(prf_we[1]),
    .prf_waddr_o(waddr[1]), .prf_wdata_o(wdata[1]), .busy_o(busy[1])
  );

  // Who should win this cycle, from the arbitration rules alone
  function automatic int pick(int k);
    if (rst) return -1;
    if (m_valid[k] && !x_ready) return -1;
    if (prau_valid && mem_valid) begin
      if (k == 1) return 1;
      return (m_last[k] == 0) ? 1 : 0;
    end
    if (prau_valid) return 0;
    if (mem_valid) return 1;
    return -1;
  endfunction

  task automatic settle;
    #1;
    for (int k = 0; k < 2; k++) exp_grant[k] = pick(k);
  endtask

  task automatic tick;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0; m_res[k] = '0; m_prf_we[k] = 1'b0;
        m_waddr[k] = '0; m_wdata[k] = '0; m_last[k] = 0;
      end else begin
        m_prf_we[k] = 1'b0;
        if (exp_grant[k] == 0) begin
          m_valid[k] = 1'b1; m_last[k] = 0;
          m_res[k] = '0;
          m_res[k].id = prau_tag.id;
          m_res[k].rd = prau_tag.addr;
          if (prau_tag.rd_is_pos) begin
            m_prf_we[k] = 1'b1; m_waddr[k] = prau_tag.addr; m_wdata[k] = prau_data;
          end else begin
            m_res[k].we = 1'b1; m_res[k].data = prau_data;
          end
        end else if (exp_grant[k] == 1) begin
          m_valid[k] = 1'b1; m_last[k] = 1;
          m_res[k] = '0;
          m_res[k].id = mem_meta.id;
          m_res[k].rd = mem_meta.rd;
          m_res[k].exc = mem_meta.exc;
          m_res[k].exccode = mem_meta.exccode;
          m_res[k].dbg = mem_meta.dbg;
          if (mem_meta.we && !mem_meta.exc) begin
            m_prf_we[k] = 1'b1; m_waddr[k] = mem_meta.rd; m_wdata[k] = mem_rdata;
          end
        end else if (x_ready) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; prau_valid = 1'b1; mem_valid = 1'b1; x_ready = 1'b1;
    settle;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (prau_ready[k] !== 1'b0 || mem_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready[%0d]: prau=%b mem=%b, need 0 0", k, prau_ready[k], mem_ready[k]);
      end
    end
    tick;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (res_valid[k] !== 1'b0 || res[k] !== '0 || prf_we[k] !== 1'b0 ||
          waddr[k] !== '0 || wdata[k] !== '0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: valid=%b res=%h we=%b waddr=%h wdata=%h, need all zero",
                 k, res_valid[k], res[k], prf_we[k], waddr[k], wdata[k]);
      end
    end
  endtask

  task automatic test_prau_int;
    x_result_t exp;
    @(negedge clk);
    rst = 1'b0; prau_valid = 1'b1; mem_valid = 1'b0; x_ready = 1'b1;
    prau_tag = '{id: 4'd3, addr: 5'd7, rd_is_pos: 1'b0};
    prau_data = 32'h4000_0000;
    settle;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (prau_ready[k] !== 1'b1 || mem_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL prau_int_ready[%0d]: prau=%b mem=%b, need 1 0", k, prau_ready[k], mem_ready[k]);
      end
    end
    tick;
    exp = '0; exp.id = 4'd3; exp.rd = 5'd7; exp.we = 1'b1; exp.data = 32'h4000_0000;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (res_valid[k] !== 1'b1 || res[k] !== exp || prf_we[k] !== 1'b0) begin
        errors++;
        $display("FAIL prau_int_result[%0d]: valid=%b res=%h prf_we=%b, need 1 %h 0",
                 k, res_valid[k], res[k], prf_we[k], exp);
      end
    end
  endtask

  task automatic test_prau_posit;
    x_result_t exp;
    @(negedge clk);
    prau_valid = 1'b1; mem_valid = 1'b0; x_ready = 1'b1;
    prau_tag = '{id: 4'd1, addr: 5'd5, rd_is_pos: 1'b1};
    prau_data = 32'h1234_5678;
    settle;
    tick;
    exp = '0; exp.id = 4'd1; exp.rd = 5'd5;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (res_valid[k] !== 1'b1 || res[k] !== exp || prf_we[k] !== 1'b1 ||
          waddr[k] !== 5'd5 || wdata[k] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL prau_posit[%0d]: res=%h prf_we=%b waddr=%0d wdata=%h, need %h 1 5 12345678",
                 k, res[k], prf_we[k], waddr[k], wdata[k], exp);
      end
    end
    // The PRF strobe must not stretch while the core stalls the result
    @(negedge clk);
    prau_valid = 1'b0; x_ready = 1'b0;
    settle;
    tick;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (prf_we[k] !== 1'b0 || res_valid[k] !== 1'b1 || res[k] !== exp) begin
        errors++;
        $display("FAIL prf_pulse[%0d]: prf_we=%b valid=%b res=%h, need 0 1 %h",
                 k, prf_we[k], res_valid[k], res[k], exp);
      end
    end
  endtask

  task automatic test_mem;
    x_result_t exp;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      prau_valid = 1'b0; mem_valid = 1'b1; x_ready = 1'b1;
      mem_meta = '{id: 4'd9, rd: 5'd2, we: 1'b1, exc: pass[0], exccode: (pass == 1) ? 6'd5 : 6'd0, dbg: 1'b0};
      mem_rdata = 32'hDEAD_BEEF;
      settle;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (mem_ready[k] !== 1'b1 || prau_ready[k] !== 1'b0) begin
          errors++;
          $display("FAIL mem_ready[%0d] pass %0d: mem=%b prau=%b, need 1 0", k, pass, mem_ready[k], prau_ready[k]);
        end
      end
      tick;
      exp = '0; exp.id = 4'd9; exp.rd = 5'd2;
      if (pass == 1) begin exp.exc = 1'b1; exp.exccode = 6'd5; end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (res_valid[k] !== 1'b1 || res[k] !== exp || prf_we[k] !== (pass == 0) ||
            (pass == 0 && (waddr[k] !== 5'd2 || wdata[k] !== 32'hDEAD_BEEF))) begin
          errors++;
          $display("FAIL mem_result[%0d] pass %0d: res=%h prf_we=%b waddr=%0d wdata=%h, need %h %b",
                   k, pass, res[k], prf_we[k], waddr[k], wdata[k], exp, (pass == 0));
        end
      end
    end
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    rst = 1'b1;
    settle;
    tick;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0; prau_valid = 1'b1; mem_valid = 1'b1; x_ready = 1'b1;
      prau_tag = '{id: 4'(i), addr: 5'(i + 10), rd_is_pos: 1'b0};
      prau_data = 32'(i * 3 + 1);
      mem_meta = '{id: 4'(i + 8), rd: 5'(i), we: 1'b0, exc: 1'b0, exccode: 6'd0, dbg: 1'b0};
      settle;
      checks++;
      if (mem_ready[0] !== (i % 2 == 0) || prau_ready[0] !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: mem=%b prau=%b, need %b %b", i, mem_ready[0], prau_ready[0],
                 (i % 2 == 0), (i % 2 == 1));
      end
      checks++;
      if (mem_ready[1] !== 1'b1 || prau_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL fixed_grant cycle %0d: mem=%b prau=%b, need 1 0", i, mem_ready[1], prau_ready[1]);
      end
      tick;
      checks++;
      if (res[0].id !== ((i % 2 == 0) ? 4'(i + 8) : 4'(i)) || res[1].id !== 4'(i + 8)) begin
        errors++;
        $display("FAIL rr_payload cycle %0d: ids %0d/%0d", i, res[0].id, res[1].id);
      end
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    prau_valid = 1'b1; mem_valid = 1'b1; x_ready = 1'b1;
    mem_meta = '{id: 4'd6, rd: 5'd17, we: 1'b0, exc: 1'b0, exccode: 6'd0, dbg: 1'b1};
    settle;
    tick;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      x_ready = 1'b0;
      mem_meta.id = 4'(s + 1);
      prau_tag.id = 4'(s + 12);
      settle;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (prau_ready[k] !== 1'b0 || mem_ready[k] !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready[%0d] cycle %0d: prau=%b mem=%b, need 0 0", k, s, prau_ready[k], mem_ready[k]);
        end
      end
      tick;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (res_valid[k] !== 1'b1 || res[k] !== m_res[k] || res[k].id !== 4'd6) begin
          errors++;
          $display("FAIL stall_payload[%0d] cycle %0d: valid=%b res=%h, need 1 %h", k, s, res_valid[k], res[k], m_res[k]);
        end
      end
    end
    @(negedge clk);
    x_ready = 1'b1;
    settle;
    checks++;
    if (prau_ready[0] !== 1'b1 || mem_ready[0] !== 1'b0 || mem_ready[1] !== 1'b1 || prau_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rr prau=%b mem=%b fixed prau=%b mem=%b, need 1 0 0 1",
               prau_ready[0], mem_ready[0], prau_ready[1], mem_ready[1]);
    end
    tick;
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    x_ready = 1'b0; rst = 1'b1;
    settle;
    tick;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (res_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stall[%0d]: valid=%b busy=%b, need 0 0", k, res_valid[k], busy[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0; prau_valid = 1'b1; mem_valid = 1'b1;
    settle;
    checks++;
    if (mem_ready[0] !== 1'b1 || prau_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL first_tie_after_reset: mem=%b prau=%b, need 1 0", mem_ready[0], prau_ready[0]);
    end
    tick;
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 59) == 0);
      prau_valid = ($urandom_range(0, 2) != 0);
      mem_valid  = ($urandom_range(0, 2) != 0);
      x_ready    = ($urandom_range(0, 3) != 0);
      prau_data  = $urandom;
      mem_rdata  = $urandom;
      prau_tag.id        = 4'($urandom_range(0, 15));
      prau_tag.addr      = 5'($urandom_range(0, 31));
      prau_tag.rd_is_pos = 1'($urandom_range(0, 1));
      mem_meta.id        = 4'($urandom_range(0, 15));
      mem_meta.rd        = 5'($urandom_range(0, 31));
      mem_meta.we        = 1'($urandom_range(0, 1));
      mem_meta.exc       = ($urandom_range(0, 3) == 0);
      mem_meta.exccode   = 6'($urandom_range(0, 63));
      mem_meta.dbg       = 1'($urandom_range(0, 1));
      settle;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (prau_ready[k] !== (exp_grant[k] == 0) || mem_ready[k] !== (exp_grant[k] == 1)) begin
          errors++;
          $display("FAIL rand_ready[%0d] cycle %0d: prau=%b mem=%b, need grant %0d", k, i,
                   prau_ready[k], mem_ready[k], exp_grant[k]);
        end
      end
      tick;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (res_valid[k] !== m_valid[k] || busy[k] !== m_valid[k] ||
            (m_valid[k] && res[k] !== m_res[k])) begin
          errors++;
          $display("FAIL rand_result[%0d] cycle %0d: valid=%b res=%h, need %b %h", k, i,
                   res_valid[k], res[k], m_valid[k], m_res[k]);
        end
        checks++;
        if (prf_we[k] !== m_prf_we[k] ||
            (m_prf_we[k] && (waddr[k] !== m_waddr[k] || wdata[k] !== m_wdata[k]))) begin
          errors++;
          $display("FAIL rand_prf[%0d] cycle %0d: we=%b addr=%0d data=%h, need %b %0d %h", k, i,
                   prf_we[k], waddr[k], wdata[k], m_prf_we[k], m_waddr[k], m_wdata[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; prau_valid = 1'b0; mem_valid = 1'b0; x_ready = 1'b0;
    prau_data = '0; mem_rdata = '0; prau_tag = '0; mem_meta = '0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_res[k] = '0; m_prf_we[k] = 1'b0;
      m_waddr[k] = '0; m_wdata[k] = '0; m_last[k] = 0; exp_grant[k] = -1;
    end
    test_reset;
    test_prau_int;
    test_prau_posit;
    test_mem;
    test_round_robin;
    test_stall;
    test_reset_mid_stall;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
